// File: rtl/neopixels.sv
// WS2812 frame driver: streams NUM_PIXELS GRB words per request on one wire, then holds a low latch.
// Optional build macro NEOPIXELS_AUTO_REFRESH_EN makes frames repeat continuously after the first request.
module neopixels #(
  parameter int         NUM_PIXELS = 8,
  parameter int         T0H_CYC    = 20,
  parameter int         T1H_CYC    = 40,
  parameter int         BIT_CYC    = 62,
  parameter int         LATCH_CYC  = 3000,
  parameter logic [7:0] BRIGHTNESS = 8'h20
) (
  input  logic       CLOCK_50,
  input  logic [1:0] KEY,
  output logic       data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND  = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;

  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam int LW = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;

  logic [1:0]    state;
  logic [CW-1:0] cyc_cnt;
  logic [4:0]    bit_cnt;
  logic [7:0]    pix_cnt;
  logic [LW-1:0] latch_cnt;
  logic [1:0]    f;
  logic [1:0]    sel;
  logic [23:0]   word;
  logic          rst_n;
  logic          req;
  logic          cur_bit;
  logic          last_cyc;
  logic          last_bit;
  logic          last_pix;
  logic          latch_done;

  assign rst_n = KEY[0];
  assign req   = ~KEY[1];

  // sel tracks (pixel + frame) mod 3 incrementally, so no divider is needed.
  always_comb begin
    word = '0;
    case (sel)
      2'd0:    word[23:16] = BRIGHTNESS;
      2'd1:    word[15:8]  = BRIGHTNESS;
      default: word[7:0]   = BRIGHTNESS;
    endcase
  end

  assign cur_bit    = word[5'd23 - bit_cnt];
  assign last_cyc   = (cyc_cnt == CW'(BIT_CYC - 1));
  assign last_bit   = (bit_cnt == 5'd23);
  assign last_pix   = (pix_cnt == 8'(NUM_PIXELS - 1));
  assign latch_done = (latch_cnt == LW'(LATCH_CYC - 1));

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state     <= IDLE;
      data      <= 1'b0;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      pix_cnt   <= '0;
      latch_cnt <= '0;
      f         <= '0;
      sel       <= '0;
    end else begin
      case (state)
        IDLE: begin
          data <= 1'b0;
          if (req) begin
            state <= SEND;
            sel   <= f;
          end
        end
        SEND: begin
          data <= (cyc_cnt < (cur_bit ? CW'(T1H_CYC) : CW'(T0H_CYC)));
          if (!last_cyc) begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end else begin
            cyc_cnt <= '0;
            if (!last_bit) begin
              bit_cnt <= bit_cnt + 5'd1;
            end else begin
              bit_cnt <= '0;
              sel     <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
              if (!last_pix) begin
                pix_cnt <= pix_cnt + 8'd1;
              end else begin
                pix_cnt <= '0;
                state   <= LATCH;
                f       <= (f == 2'd2) ? 2'd0 : f + 2'd1;
              end
            end
          end
        end
        LATCH: begin
          data <= 1'b0;
          if (!latch_done) begin
            latch_cnt <= latch_cnt + LW'(1);
          end else begin
            latch_cnt <= '0;
`ifdef NEOPIXELS_AUTO_REFRESH_EN
            state <= SEND;
            sel   <= f;
`else
            state <= IDLE;
`endif
          end
        end
        default: begin
          state <= IDLE;
          data  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neopixels.sv
// Bench for neopixels: a per-cycle waveform model of each frame is compared against data every cycle,
// with directed timing, pattern, reset-abort and retrigger checks pinning the model.
module tb_neopixels;

  localparam int         NP    = 8;
  localparam int         T0H   = 20;
  localparam int         T1H   = 40;
  localparam int         BITC  = 62;
  localparam int         LATCH = 3000;
  localparam logic [7:0] BR    = 8'h20;

  logic       clk = 1'b0;
  logic [1:0] key = 2'b00;
  logic       data;

  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   rise_cnt = 0;
  int   m_f      = 0;
  bit   started  = 1'b0;
  logic exp_data = 1'b0;
  logic [0:0] exp_q[$];

  neopixels dut (
    .CLOCK_50(clk),
    .KEY     (key),
    .data    (data)
  );

  always #10 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endfunction

  // Expected data for every cycle of one frame plus its latch, built straight from the colour and bit-timing rules.
  function automatic void push_frame();
    for (int p = 0; p < NP; p++) begin
      int sel;
      logic [23:0] w;
      sel = (p + m_f) % 3;
      w   = 24'(BR) << (8 * (2 - sel));
      for (int b = 23; b >= 0; b--) begin
        int hi;
        hi = w[b] ? T1H : T0H;
        for (int c = 0; c < BITC; c++) exp_q.push_back(1'(c < hi));
      end
    end
    for (int c = 0; c < LATCH; c++) exp_q.push_back(1'b0);
    m_f = (m_f + 1) % 3;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (key[0] == 1'b0) begin
      exp_q.delete();
      exp_data = 1'b0;
      m_f      = 0;
      started  = 1'b1;
    end else if (exp_q.size() > 0) begin
      exp_data = exp_q.pop_front();
    end else begin
      exp_data = 1'b0;
      if (key[1] == 1'b0) push_frame();
    end
  end

  always @(negedge clk) begin
    if (started) check("data_stream", {31'd0, data}, {31'd0, exp_data});
  end

  always @(posedge data) begin
    if (started) rise_cnt++;
  end

  task automatic run_len(input logic v, input int limit, output int n);
    n = 0;
    while (data === v && n < limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_rise(input int limit, output bit ok);
    int n;
    n = 0;
    while (data !== 1'b1 && n < limit) begin
      n++;
      @(negedge clk);
    end
    ok = (data === 1'b1);
  endtask

  task automatic wait_gap_rise(output bit ok, output int t);
    int low;
    int n;
    low = 0;
    n   = 0;
    ok  = 1'b0;
    while (n < 40000) begin
      if (data === 1'b1 && low >= 100) begin
        ok = 1'b1;
        break;
      end
      low = (data === 1'b0) ? low + 1 : 0;
      n++;
      @(negedge clk);
    end
    t = cyc;
  endtask

  // Decodes 24 bits starting at the first high sample of a bit: a long high pulse is a 1.
  task automatic read_word(output logic [23:0] w);
    int h;
    int l;
    w = '0;
    for (int b = 0; b < 24; b++) begin
      run_len(1'b1, 200, h);
      run_len(1'b0, 200, l);
      w = {w[22:0], 1'(h > 30)};
    end
  endtask

  initial begin
    int n;
    int t0;
    int t_a;
    int t_b;
    int t_c;
    int r0;
    int last_hi;
    int low;
    bit ok;
    logic [23:0] w;

    // Reset and quiet idle.
    key = 2'b00;
    @(negedge clk);
    key = 2'b11;
    check("reset_data", {31'd0, data}, 32'd0);
    repeat (5000) @(negedge clk);
    check("idle_no_rise", rise_cnt, 32'd0);
    check("idle_data", {31'd0, data}, 32'd0);

    // Trigger and first-bit timing of frame f=0, pixel 0 = 0x200000.
    key = 2'b01;
    @(negedge clk);
    check("trigger_edge_low", {31'd0, data}, 32'd0);
    key = 2'b11;
    @(negedge clk);
    check("first_rise", {31'd0, data}, 32'd1);
    t0 = cyc;
    run_len(1'b1, 200, n); check("b7_high", n, 32'd20);
    run_len(1'b0, 200, n); check("b7_low",  n, 32'd42);
    run_len(1'b1, 200, n); check("b6_high", n, 32'd20);
    run_len(1'b0, 200, n); check("b6_low",  n, 32'd42);
    run_len(1'b1, 200, n); check("b5_high", n, 32'd40);
    run_len(1'b0, 200, n); check("b5_low",  n, 32'd22);

    // Frame length: last pixel word is 0x002000, so its final bit is a 0 whose high ends 42 cycles before the frame end.
    last_hi = t0;
    low     = 0;
    n       = 0;
    while (low < 100 && n < 20000) begin
      if (data === 1'b1) begin
        last_hi = cyc;
        low     = 0;
      end else begin
        low++;
      end
      n++;
      @(negedge clk);
    end
    check("last_high_offset", last_hi - t0, 32'd11861);
    run_len(1'b0, 3100, n);
    check("latch_low_ge_3000", {31'd0, 1'((low + n - 42) >= 3000)}, 32'd1);

    // Reset mid-frame (frame counter is 1 here), then the next frame must restart at f=0.
    key = 2'b01;
    @(negedge clk);
    key = 2'b11;
    wait_rise(200, ok);
    check("abort_frame_rise", {31'd0, ok}, 32'd1);
    repeat (129) @(negedge clk);
    check("pre_abort_high", {31'd0, data}, 32'd1);
    key = 2'b00;
    @(negedge clk);
    check("abort_low", {31'd0, data}, 32'd0);
    key = 2'b11;
    repeat (3) @(negedge clk);
    check("abort_idle", {31'd0, data}, 32'd0);

    // Held request: back-to-back frames with the rotating pattern.
    key = 2'b01;
    wait_rise(200, ok);
    check("f0_rise", {31'd0, ok}, 32'd1);
    t_a = cyc;
    read_word(w); check("f0_p0", {8'd0, w}, 32'h200000);
    read_word(w); check("f0_p1", {8'd0, w}, 32'h002000);
    wait_gap_rise(ok, t_b);
    check("f1_rise", {31'd0, ok}, 32'd1);
    check("frame_interval_1", t_b - t_a, 32'd14905);
    read_word(w); check("f1_p0", {8'd0, w}, 32'h002000);
    wait_gap_rise(ok, t_c);
    check("f2_rise", {31'd0, ok}, 32'd1);
    check("frame_interval_2", t_c - t_b, 32'd14905);
    r0 = rise_cnt;
    read_word(w); check("f2_p0", {8'd0, w}, 32'h000020);

    // Request pulse during SEND must not add a frame.
    key = 2'b11;
    repeat (300) @(negedge clk);
    key = 2'b01;
    @(negedge clk);
    key = 2'b11;
    repeat (13500) @(negedge clk);
    check("one_frame_rises", rise_cnt - r0, 32'd191);
    check("final_idle", {31'd0, data}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
